dc_bu_line_scheduler: RTL and testbench
=======================================

Name: dc_bu_line_scheduler

Overview:
- Vertical line scheduler for the buffering unit's five-buffer rotation (one write buffer plus y0..y3 filter taps).
- Decides when the buffer-function rotation may advance, using source-line writes and output-line requests.
- Primes the four tap buffers at frame start and accumulates the vertical scale step per output line.
- Grants output lines once taps y0..y3 hold source rows top..top+3 for the required position; supplies the fractional phase to the vertical filter.

Parameters:
- LINE_W, 11, width of line counters and row indices.
- FRAC_W, 8, fractional bits of the vertical step and phase.
- STEP_W, 12, width of v_step (unsigned, format Q(STEP_W-FRAC_W).FRAC_W).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  clock enable; when low, all state holds and no pulses are issued.
- frame_start  in  1  pulse; samples the configuration and restarts scheduling.
- v_step  in  STEP_W  source lines advanced per output line; sampled on frame_start.
- src_lines  in  LINE_W  number of source lines per frame; sampled on frame_start; must be >= 4.
- out_lines  in  LINE_W  number of output lines per frame; sampled on frame_start.
- wr_line_done  in  1  pulse from the writer: the write buffer has been filled with one source line.
- wr_allow  out  1  the writer may fill the write buffer.
- out_line_req  in  1  level request from the output side for the next line.
- out_line_grant  out  1  single-cycle grant.
- v_frac  out  FRAC_W  phase for the granted line.
- next_line  out  1  rotation pulse to the buffer-function manager.
- no_func_switch  out  1  rotation inhibit to the buffer-function manager.
- busy  out  1  high in PRIME, READY and ADVANCE.
- cfg_err  out  1  sticky flag: src_lines < 4 was sampled on frame_start.
- wr_err  out  1  sticky flag: wr_line_done arrived while wr_allow was low.

Behaviour:
- Reset values: state=IDLE, all outputs 0 except no_func_switch=1. Internal registers also clear: acc, top, rows_written, grants, wr_full.
- All outputs are registered. The manager rotates only on next_line=1 with no_func_switch=0.
- no_func_switch=1 in IDLE and DONE, and whenever en=0.
- wr_allow = wr_full==0 and rows_written < src_lines and state is not IDLE or DONE.
- On wr_line_done with wr_allow=1: set wr_full and increment rows_written. Otherwise the pulse is ignored and wr_err is set.
- Each next_line pulse clears wr_full on the same edge. At most one next_line is issued per cycle.
- frame_start (in any state, with en=1):
  - Clear acc, top, rows_written, grants, wr_full, next_line and grant.
  - Latch the configuration.
  - If src_lines < 4: set cfg_err and go to IDLE. Otherwise go to PRIME.
  - frame_start has priority over every other event in the same cycle.
- PRIME:
  - Each accepted wr_line_done produces next_line one cycle later.
  - After the 4th rotation, y0..y3 hold rows 0..3 and top=0; go to READY.
- target = min(acc[LINE_W+FRAC_W-1:FRAC_W], src_lines-4). This is the bottom-edge clamp.
  - Rotation from top to top+1 needs row top+4 in the write buffer.
  - Row top+4 always exists while top < target, so no rotation waits on a nonexistent line.
- READY:
  - Wait for out_line_req=1.
  - If top==target: on the next edge, pulse out_line_grant, set v_frac = acc[FRAC_W-1:0], do acc += v_step (saturating at all-ones) and grants++.
  - If top < target: go to ADVANCE.
- ADVANCE:
  - While top < target and wr_full=1: pulse next_line and top++.
  - When top==target: grant as in READY, then return to READY.
- v_frac holds its value between grants.
- out_line_req must stay high until the grant and drop on the cycle after it. The request is not re-sampled on the grant cycle.
- When grants reaches out_lines: go to DONE (no grant and no rotation; wr_allow=0). Leave DONE only on frame_start.
- out_lines=0 means the block leaves PRIME directly to DONE.

Test Plan:
- Reset with en=1 -> no_func_switch=1, state IDLE, all other outputs 0. A later frame_start with src_lines=8 -> wr_allow=1 and busy=1 on the next cycle.
- frame_start with v_step=0x100, src_lines=8, out_lines=8, then 4 wr_line_done pulses -> exactly 4 next_line pulses, each one cycle after its wr_line_done; READY with top=0.
- Same frame, out_line_req held high with rows written on demand -> grants for rows 0,1,2,3,4,4,4,4 with v_frac=0. The last 3 grants issue no next_line (clamp at src_lines-4=4). DONE after 8 grants.
- v_step=0x080 (2x upscale), src_lines=6, out_lines=4 -> v_frac sequence 0x00,0x80,0x00,0x80. Exactly one next_line occurs between grants 2 and 3 and waits for wr_line_done.
- wr_line_done issued while wr_full=1 -> wr_err=1 and rows_written unchanged; frame_start with src_lines=3 -> cfg_err=1 and state IDLE.
- frame_start mid-ADVANCE with en toggling low -> no pulses while en=0. Restart clears top/acc and re-enters PRIME. Async rst mid-frame -> immediate IDLE values.

Source files
------------

// File: rtl/dc_bu_line_scheduler.sv
// ---------------------------------------------------------------------------
// dc_bu_line_scheduler
//
// Vertical line scheduler for the buffering unit's five-buffer rotation
// (one write buffer plus filter taps y0..y3). It primes the four taps at
// frame start, then grants output lines once taps y0..y3 hold source rows
// top..top+3. For each granted line it supplies the fractional phase and
// advances the vertical accumulator by v_step.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  clock enable; low holds all state, issues no pulses
//   frame_start         restart pulse; samples v_step/src_lines/out_lines
//   v_step              Q(STEP_W-FRAC_W).FRAC_W source lines per output line
//   src_lines           source lines per frame (>= 4)
//   out_lines           output lines per frame
//   wr_line_done        writer filled the write buffer with one source line
//   wr_allow            writer may fill the write buffer
//   out_line_req        level request for the next output line
//   out_line_grant      single-cycle grant
//   v_frac              phase of the most recently granted line
//   next_line           rotation pulse to the buffer-function manager
//   no_func_switch      rotation inhibit to the buffer-function manager
//   busy                frame in progress (PRIME, READY, ADVANCE)
//   cfg_err             sticky: src_lines < 4 sampled on frame_start
//   wr_err              sticky: wr_line_done while wr_allow was low
// ---------------------------------------------------------------------------
module dc_bu_line_scheduler #(
  parameter int LINE_W = 11,
  parameter int FRAC_W = 8,
  parameter int STEP_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              frame_start,
  input  logic [STEP_W-1:0] v_step,
  input  logic [LINE_W-1:0] src_lines,
  input  logic [LINE_W-1:0] out_lines,
  input  logic              wr_line_done,
  output logic              wr_allow,
  input  logic              out_line_req,
  output logic              out_line_grant,
  output logic [FRAC_W-1:0] v_frac,
  output logic              next_line,
  output logic              no_func_switch,
  output logic              busy,
  output logic              cfg_err,
  output logic              wr_err
);

  localparam int ACC_W = LINE_W + FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRIME   = 3'd1,
    S_READY   = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [ACC_W-1:0]    acc, acc_n;
  logic [LINE_W-1:0]   top, top_n;
  logic [LINE_W-1:0]   rows_written, rows_n;
  logic [LINE_W-1:0]   grants, grants_n;
  logic                wr_full, wr_full_n;
  logic [STEP_W-1:0]   step_q, step_n;
  logic [LINE_W-1:0]   src_q, src_n;
  logic [LINE_W-1:0]   out_q, out_n;

  logic                wr_allow_n, grant_n, next_line_n, nfs_n, busy_n;
  logic                cfg_err_n, wr_err_n;
  logic [FRAC_W-1:0]   v_frac_n;

  logic [LINE_W-1:0]   acc_int, bottom, target;
  logic                wr_accept, do_grant;

  // Accumulator step that pins at all-ones instead of wrapping, so a long
  // frame with a large step never folds back to the top of the image.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [STEP_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - STEP_W){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // Bottom-edge clamp: the top tap never passes src_lines-4, so every
  // rotation needs a row that actually exists in the source frame.
  assign acc_int = acc[ACC_W-1:FRAC_W];
  assign bottom  = src_q - LINE_W'(4);
  assign target  = (acc_int < bottom) ? acc_int : bottom;

  assign wr_accept = wr_line_done && wr_allow;

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    top_n       = top;
    rows_n      = rows_written;
    grants_n    = grants;
    wr_full_n   = wr_full;
    step_n      = step_q;
    src_n       = src_q;
    out_n       = out_q;
    next_line_n = 1'b0;
    grant_n     = 1'b0;
    v_frac_n    = v_frac;
    cfg_err_n   = cfg_err;
    wr_err_n    = wr_err;
    do_grant    = 1'b0;

    if (en) begin
      if (frame_start) begin
        acc_n     = '0;
        top_n     = '0;
        rows_n    = '0;
        grants_n  = '0;
        wr_full_n = 1'b0;
        step_n    = v_step;
        src_n     = src_lines;
        out_n     = out_lines;
        if (src_lines < LINE_W'(4)) begin
          cfg_err_n = 1'b1;
          state_n   = S_IDLE;
        end else begin
          state_n   = S_PRIME;
        end
      end else begin
        // The manager consumes the write buffer on the edge it samples
        // next_line, so the buffer is free again from the next cycle.
        if (next_line) wr_full_n = 1'b0;
        if (wr_line_done) begin
          if (wr_allow) begin
            wr_full_n = 1'b1;
            rows_n    = rows_written + 1'b1;
          end else begin
            wr_err_n  = 1'b1;
          end
        end

        case (state)
          S_PRIME: begin
            if (wr_accept) next_line_n = 1'b1;
            if (next_line && (rows_written == LINE_W'(4)))
              state_n = (out_q == '0) ? S_DONE : S_READY;
          end
          S_READY: begin
            // The grant cycle itself never re-samples the request.
            if (out_line_req && !out_line_grant) begin
              if (top == target) do_grant = 1'b1;
              else               state_n  = S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            if (top < target) begin
              // Skip the cycle where the previous pulse is still out so
              // one filled buffer never yields two rotations.
              if (wr_full && !next_line) begin
                next_line_n = 1'b1;
                top_n       = top + 1'b1;
              end
            end else begin
              do_grant = 1'b1;
            end
          end
          default: ;
        endcase

        if (do_grant) begin
          grant_n  = 1'b1;
          v_frac_n = acc[FRAC_W-1:0];
          acc_n    = sat_add(acc, step_q);
          grants_n = grants + 1'b1;
          state_n  = ((grants + 1'b1) == out_q) ? S_DONE : S_READY;
        end
      end
    end

    busy_n     = (state_n == S_PRIME) || (state_n == S_READY) ||
                 (state_n == S_ADVANCE);
    nfs_n      = !en || (state_n == S_IDLE) || (state_n == S_DONE);
    wr_allow_n = !wr_full_n && (rows_n < src_n) &&
                 (state_n != S_IDLE) && (state_n != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      acc            <= '0;
      top            <= '0;
      rows_written   <= '0;
      grants         <= '0;
      wr_full        <= 1'b0;
      step_q         <= '0;
      src_q          <= '0;
      out_q          <= '0;
      wr_allow       <= 1'b0;
      out_line_grant <= 1'b0;
      v_frac         <= '0;
      next_line      <= 1'b0;
      no_func_switch <= 1'b1;
      busy           <= 1'b0;
      cfg_err        <= 1'b0;
      wr_err         <= 1'b0;
    end else begin
      state          <= state_n;
      acc            <= acc_n;
      top            <= top_n;
      rows_written   <= rows_n;
      grants         <= grants_n;
      wr_full        <= wr_full_n;
      step_q         <= step_n;
      src_q          <= src_n;
      out_q          <= out_n;
      wr_allow       <= wr_allow_n;
      out_line_grant <= grant_n;
      v_frac         <= v_frac_n;
      next_line      <= next_line_n;
      no_func_switch <= nfs_n;
      busy           <= busy_n;
      cfg_err        <= cfg_err_n;
      wr_err         <= wr_err_n;
    end
  end

endmodule

// File: tb/tb_dc_bu_line_scheduler.sv
module tb_dc_bu_line_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        frame_start = 1'b0;
  logic [11:0] v_step = '0;
  logic [10:0] src_lines = '0;
  logic [10:0] out_lines = '0;
  logic        wr_line_done = 1'b0;
  logic        wr_allow;
  logic        out_line_req = 1'b0;
  logic        out_line_grant;
  logic [7:0]  v_frac;
  logic        next_line;
  logic        no_func_switch;
  logic        busy;
  logic        cfg_err;
  logic        wr_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dc_bu_line_scheduler #(.LINE_W(11), .FRAC_W(8), .STEP_W(12)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
    .v_step(v_step), .src_lines(src_lines), .out_lines(out_lines),
    .wr_line_done(wr_line_done), .wr_allow(wr_allow),
    .out_line_req(out_line_req), .out_line_grant(out_line_grant),
    .v_frac(v_frac), .next_line(next_line), .no_func_switch(no_func_switch),
    .busy(busy), .cfg_err(cfg_err), .wr_err(wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [11:0] s, input logic [10:0] sl, input logic [10:0] ol);
    frame_start = 1'b1;
    v_step = s;
    src_lines = sl;
    out_lines = ol;
    tick();
    frame_start = 1'b0;
  endtask

  // Four directed writes; each must rotate exactly one cycle later.
  task automatic prime(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " allow"}, wr_allow, 1);
      wr_line_done = 1'b1;
      tick();
      wr_line_done = 1'b0;
      chk({tag, " nl_hi"}, next_line, 1);
      tick();
      chk({tag, " nl_lo"}, next_line, 0);
    end
  endtask

  // Hold the request until the grant (writing rows on demand if auto),
  // keep it high through the grant cycle, then drop it.
  task automatic request(input bit auto_wr, input logic [7:0] exp_frac,
                         input int exp_rot, input string tag);
    int rot;
    bit got;
    rot = 0;
    got = 1'b0;
    out_line_req = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      wr_line_done = auto_wr ? wr_allow : 1'b0;
      tick();
      if (next_line) rot++;
      if (out_line_grant) got = 1'b1;
    end
    wr_line_done = 1'b0;
    chk({tag, " granted"}, got, 1);
    chk({tag, " v_frac"}, v_frac, exp_frac);
    chk({tag, " rotations"}, rot, exp_rot);
    tick();
    chk({tag, " grant_single"}, out_line_grant, 0);
    out_line_req = 1'b0;
  endtask

  int rots3 [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  int quiet;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst nfs", no_func_switch, 1);
    chk("rst busy", busy, 0);
    chk("rst wr_allow", wr_allow, 0);
    chk("rst grant", out_line_grant, 0);
    chk("rst next_line", next_line, 0);
    chk("rst v_frac", v_frac, 0);
    chk("rst cfg_err", cfg_err, 0);
    chk("rst wr_err", wr_err, 0);
    rst = 1'b0;
    tick();
    chk("idle nfs", no_func_switch, 1);
    chk("idle busy", busy, 0);

    // Unit step, 8 in / 8 out: prime then clamp at row 4
    do_frame(12'h100, 11'd8, 11'd8);
    chk("t1 wr_allow", wr_allow, 1);
    chk("t1 busy", busy, 1);
    chk("t1 nfs", no_func_switch, 0);
    prime("t2");
    chk("t2 busy", busy, 1);
    chk("t2 top", dut.top, 0);
    chk("t2 ready", dut.state, 2);
    for (int i = 0; i < 8; i++)
      request(1'b1, 8'h00, rots3[i], $sformatf("t3 g%0d", i));
    chk("t3 done busy", busy, 0);
    chk("t3 done nfs", no_func_switch, 1);
    chk("t3 done wr_allow", wr_allow, 0);

    // 2x upscale, 6 in / 4 out
    do_frame(12'h080, 11'd6, 11'd4);
    prime("t4");
    request(1'b0, 8'h00, 0, "t4 g0");
    request(1'b0, 8'h80, 0, "t4 g1");
    out_line_req = 1'b1;
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (next_line || out_line_grant) quiet++;
    end
    chk("t4 waits for row", quiet, 0);
    chk("t4 allow row4", wr_allow, 1);
    wr_line_done = 1'b1;
    tick();
    wr_line_done = 1'b0;
    request(1'b0, 8'h00, 1, "t4 g2");
    request(1'b0, 8'h80, 0, "t4 g3");
    chk("t4 done busy", busy, 0);

    // Write overrun and bad configuration
    do_frame(12'h100, 11'd8, 11'd8);
    chk("t5 v_frac held", v_frac, 8'h80);
    prime("t5");
    chk("t5 wr_err clear", wr_err, 0);
    wr_line_done = 1'b1;
    tick();
    wr_line_done = 1'b0;
    chk("t5 full blocks", wr_allow, 0);
    chk("t5 rows", dut.rows_written, 5);
    wr_line_done = 1'b1;
    tick();
    wr_line_done = 1'b0;
    chk("t5 wr_err", wr_err, 1);
    chk("t5 rows kept", dut.rows_written, 5);
    do_frame(12'h100, 11'd3, 11'd8);
    chk("t5 cfg_err", cfg_err, 1);
    chk("t5 cfg idle busy", busy, 0);
    chk("t5 cfg idle allow", wr_allow, 0);
    chk("t5 cfg idle nfs", no_func_switch, 1);

    // Enable gating mid-ADVANCE, restart, async reset
    do_frame(12'h300, 11'd8, 11'd8);
    prime("t6");
    request(1'b0, 8'h00, 0, "t6 g0");
    out_line_req = 1'b1;
    tick();
    tick();
    chk("t6 advance", dut.state, 3);
    wr_line_done = 1'b1;
    tick();
    wr_line_done = 1'b0;
    tick();
    chk("t6 rotate", next_line, 1);
    tick();
    chk("t6 top1", dut.top, 1);
    en = 1'b0;
    quiet = 0;
    for (int c = 0; c < 5; c++) begin
      wr_line_done = (c == 1);
      frame_start = (c == 3);
      tick();
      if (next_line || out_line_grant) quiet++;
    end
    wr_line_done = 1'b0;
    frame_start = 1'b0;
    chk("t6 no pulses en0", quiet, 0);
    chk("t6 nfs en0", no_func_switch, 1);
    chk("t6 top held", dut.top, 1);
    chk("t6 wr_full held", dut.wr_full, 0);
    en = 1'b1;
    out_line_req = 1'b0;
    do_frame(12'h100, 11'd8, 11'd2);
    chk("t6 restart top", dut.top, 0);
    chk("t6 restart acc", dut.acc, 0);
    chk("t6 restart busy", busy, 1);
    chk("t6 restart prime", dut.state, 1);
    prime("t6r");
    request(1'b1, 8'h00, 0, "t6r g0");
    #3;
    rst = 1'b1;
    #1;
    chk("t6 arst busy", busy, 0);
    chk("t6 arst nfs", no_func_switch, 1);
    chk("t6 arst allow", wr_allow, 0);
    chk("t6 arst cfg_err", cfg_err, 0);
    chk("t6 arst wr_err", wr_err, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6 post nfs", no_func_switch, 1);
    chk("t6 post busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
